// File: rtl/kuznechik_cipher_arbiter.sv
// rtl/kuznechik_cipher_arbiter.sv - round-robin arbiter sharing one kuznechik core
// Sequences issue/wait/response/ack per transaction; a watchdog turns core stalls into error responses plus a core reset.
module kuznechik_cipher_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RST_CYCLES     = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [N_REQ-1:0]           req_valid_i,
   output logic [N_REQ-1:0]           req_ready_o,
   input  logic [N_REQ*128-1:0]       req_data_i,
   output logic [N_REQ-1:0]           rsp_valid_o,
   input  logic [N_REQ-1:0]           rsp_ready_i,
   output logic [127:0]               rsp_data_o,
   output logic                       rsp_err_o,
   output logic [$clog2(N_REQ)-1:0]   active_id_o,
   output logic                       core_rstn_o,
   output logic                       core_req_o,
   output logic                       core_ack_o,
   output logic [127:0]               core_data_o,
   input  logic                       core_busy_i,
   input  logic                       core_valid_i,
   input  logic [127:0]               core_data_i
);
   localparam int ID_W = $clog2(N_REQ);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ACK, S_RECOVER
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [ID_W-1:0]   active_id_q, active_id_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [RC_W-1:0]   rcnt_q, rcnt_d;
   logic [127:0]      core_data_q, core_data_d;
   logic [127:0]      rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              core_rstn_q, core_rstn_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   scan_id;
   logic [N_REQ-1:0]  req_ready;
   logic [N_REQ-1:0]  rsp_valid;

   // First valid requester at or after the rr pointer, wrapping modulo N_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      scan_id   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_id = ID_W'((int'(rr_q) + i) % N_REQ);
         if (!gnt_found && req_valid_i[scan_id]) begin
            gnt_found = 1'b1;
            gnt_id    = scan_id;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && core_rstn_q && gnt_found) begin
         req_ready[gnt_id] = 1'b1;
      end
      rsp_valid = '0;
      if (state_q == S_RESP) begin
         rsp_valid[active_id_q] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      active_id_d = active_id_q;
      wdog_d      = wdog_q;
      rcnt_d      = rcnt_q;
      core_data_d = core_data_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      core_rstn_d = core_rstn_q;
      case (state_q)
         S_IDLE: begin
            core_rstn_d = 1'b1;
            if (req_ready != '0) begin
               core_data_d = req_data_i[int'(gnt_id)*128 +: 128];
               active_id_d = gnt_id;
               rr_d        = ID_W'((int'(gnt_id) + 1) % N_REQ);
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!core_busy_i) begin
               wdog_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wdog_q != WD_W'(TIMEOUT_CYCLES)) begin
               wdog_d = wdog_q + 1'b1;
            end
            // A result arriving on the watchdog's last cycle still counts as success.
            if (core_valid_i) begin
               rsp_data_d = core_data_i;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (wdog_d == WD_W'(TIMEOUT_CYCLES)) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i[active_id_q]) begin
               if (rsp_err_q) begin
                  core_rstn_d = 1'b0;
                  rcnt_d      = '0;
                  state_d     = S_RECOVER;
               end else begin
                  state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         S_RECOVER: begin
            if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
               core_rstn_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         active_id_q <= '0;
         wdog_q      <= '0;
         rcnt_q      <= '0;
         core_data_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         core_rstn_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         active_id_q <= active_id_d;
         wdog_q      <= wdog_d;
         rcnt_q      <= rcnt_d;
         core_data_q <= core_data_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         core_rstn_q <= core_rstn_d;
      end
   end

   // The request pulse follows busy combinationally so it fires on the cycle busy falls.
   assign core_req_o  = (state_q == S_ISSUE) && !core_busy_i;
   assign core_ack_o  = (state_q == S_ACK);
   assign req_ready_o = req_ready;
   assign rsp_valid_o = rsp_valid;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign active_id_o = active_id_q;
   assign core_rstn_o = core_rstn_q;
   assign core_data_o = core_data_q;
endmodule
